// File: rtl/pwm_pkg.sv
// Shared types and reset defaults for the multi-channel PWM block.
package pwm_pkg;
   typedef enum logic {ALIGN_EDGE = 1'b0, ALIGN_CENTER = 1'b1} align_e;
   typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

   localparam int CNT_W_DEF      = 18;
   localparam int N_CH_DEF       = 4;
   localparam int PERIOD_RST_DEF = 200000;
   localparam int DUTY_RST_DEF   = 20000;
endpackage

// File: rtl/pwm_channel.sv
// One PWM output: double-buffered duty register and the registered compare against the shared counter.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int DUTY_RST = DUTY_RST_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             boundary,
   input  logic             pending,
   input  logic             load,
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W-1:0] duty,
   output logic             out
);
   logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
   logic [CNT_W-1:0] duty_act_q, duty_act_d;
   logic [CNT_W-1:0] duty_eff;
   logic             out_q, out_d;

   always_comb begin
      // The shadow is bypassed at the boundary so the first compare of a period already uses the new duty.
      duty_eff   = (boundary && pending) ? duty_sh_q : duty_act_q;
      duty_act_d = duty_eff;
      duty_sh_d  = load ? duty : duty_sh_q;
      out_d      = en && (cnt < duty_eff);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         duty_sh_q  <= CNT_W'(DUTY_RST);
         duty_act_q <= CNT_W'(DUTY_RST);
         out_q      <= 1'b0;
      end else begin
         duty_sh_q  <= duty_sh_d;
         duty_act_q <= duty_act_d;
         out_q      <= out_d;
      end
   end

   assign out = out_q;
endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: a shared edge- or center-aligned period counter feeding N_CH duty comparators,
// with double-buffered period/duty that switch over only at period boundaries.
module pwm_multi_channel
   import pwm_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int N_CH       = N_CH_DEF,
   parameter int ALIGN      = 0,
   parameter int PERIOD_RST = PERIOD_RST_DEF,
   parameter int DUTY_RST   = DUTY_RST_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [CNT_W-1:0]      period,
   input  logic [N_CH*CNT_W-1:0] duty,
   input  logic                  load,
   output logic [N_CH-1:0]       out,
   output logic                  period_tick,
   output logic                  load_pending
);
   localparam align_e MODE = (ALIGN != 0) ? ALIGN_CENTER : ALIGN_EDGE;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   dir_e             dir_q, dir_d;
   logic [CNT_W-1:0] per_sh_q, per_sh_d;
   logic [CNT_W-1:0] per_act_q, per_act_d;
   logic [CNT_W-1:0] per_eff, per_last;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             boundary, apply;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q     <= '0;
         dir_q     <= UP;
         per_sh_q  <= CNT_W'(PERIOD_RST);
         per_act_q <= CNT_W'(PERIOD_RST);
         pend_q    <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         per_sh_q  <= per_sh_d;
         per_act_q <= per_act_d;
         pend_q    <= pend_d;
         tick_q    <= tick_d;
      end
   end

   always_comb begin
      per_eff   = apply ? per_sh_q : per_act_q;
      // A zero period behaves as a one-count period.
      per_last  = (per_eff == '0) ? '0 : per_eff - CNT_W'(1);
      per_act_d = per_eff;
      per_sh_d  = load ? period : per_sh_q;
      pend_d    = load || (pend_q && !boundary);
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      if (!en) begin
         cnt_d = '0;
         dir_d = UP;
      end else if (MODE == ALIGN_EDGE) begin
         cnt_d = (cnt_q == per_last) ? '0 : cnt_q + CNT_W'(1);
      end else begin
         // Turnarounds hold the end value for one extra cycle, giving a 2P-cycle period.
         case (dir_q)
            UP:      if (cnt_q == per_last) dir_d = DOWN; else cnt_d = cnt_q + CNT_W'(1);
            DOWN:    if (cnt_q == '0) dir_d = UP; else cnt_d = cnt_q - CNT_W'(1);
            default: dir_d = UP;
         endcase
      end
   end

   always_comb begin
      boundary = !en || (cnt_q == '0 && dir_q == UP);
      apply    = boundary && pend_q;
      tick_d   = en && boundary;
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      pwm_channel #(.CNT_W(CNT_W), .DUTY_RST(DUTY_RST)) u_ch (
         .clk      (clk),
         .reset    (reset),
         .en       (en),
         .boundary (boundary),
         .pending  (pend_q),
         .load     (load),
         .cnt      (cnt_q),
         .duty     (duty[i*CNT_W +: CNT_W]),
         .out      (out[i])
      );
   end

   assign period_tick  = tick_q;
   assign load_pending = pend_q;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: edge and center instances share stimulus, checked against a phase-based model.
module tb_pwm_multi_channel;
   localparam int CW = 8;
   localparam int NC = 4;
   localparam int PR = 20;
   localparam int DR = 5;

   logic            clk = 1'b0;
   logic            reset, en, load;
   logic [CW-1:0]   period;
   logic [NC*CW-1:0] duty;
   logic [NC-1:0]   dout [2];
   logic            dtick [2];
   logic            dpend [2];

   int vec = 0, errs = 0;
   int hi [2][NC];
   int tk [2];

   // Model: position within the period (0..len-1), active/shadow values, pending flag.
   int          m_ph [2], m_pa [2], m_ps [2];
   int          m_da [2][NC], m_ds [2][NC];
   bit          m_pend [2];
   logic [NC-1:0] m_out [2];
   logic        m_tick [2];

   always #5 clk = ~clk;

   pwm_multi_channel #(.CNT_W(CW), .N_CH(NC), .ALIGN(0), .PERIOD_RST(PR), .DUTY_RST(DR)) u_edge (
      .clk(clk), .reset(reset), .en(en), .period(period), .duty(duty), .load(load),
      .out(dout[0]), .period_tick(dtick[0]), .load_pending(dpend[0]));

   pwm_multi_channel #(.CNT_W(CW), .N_CH(NC), .ALIGN(1), .PERIOD_RST(PR), .DUTY_RST(DR)) u_ctr (
      .clk(clk), .reset(reset), .en(en), .period(period), .duty(duty), .load(load),
      .out(dout[1]), .period_tick(dtick[1]), .load_pending(dpend[1]));

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_ph[m] = 0; m_pa[m] = PR; m_ps[m] = PR; m_pend[m] = 0;
         m_out[m] = '0; m_tick[m] = 1'b0;
         for (int c = 0; c < NC; c++) begin m_da[m][c] = DR; m_ds[m][c] = DR; end
      end
   endtask

   task automatic model_step();
      for (int m = 0; m < 2; m++) begin
         bit bnd;
         int p, len, pos;
         bnd = !en || m_ph[m] == 0;
         if (bnd && m_pend[m]) begin
            m_pa[m] = m_ps[m];
            for (int c = 0; c < NC; c++) m_da[m][c] = m_ds[m][c];
         end
         p   = (m_pa[m] == 0) ? 1 : m_pa[m];
         len = (m == 1) ? 2 * p : p;
         pos = (m == 0 || m_ph[m] < p) ? m_ph[m] : 2 * p - 1 - m_ph[m];
         for (int c = 0; c < NC; c++) m_out[m][c] = en && (pos < m_da[m][c]);
         m_tick[m] = en && m_ph[m] == 0;
         m_ph[m]   = en ? (m_ph[m] + 1) % len : 0;
         if (load) begin
            m_ps[m] = int'(period);
            for (int c = 0; c < NC; c++) m_ds[m][c] = int'(duty[c*CW +: CW]);
            m_pend[m] = 1;
         end else if (bnd) m_pend[m] = 0;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      for (int m = 0; m < 2; m++) begin
         tk[m] += int'(dtick[m]);
         for (int c = 0; c < NC; c++) hi[m][c] += int'(dout[m][c]);
      end
   endtask

   task automatic clr();
      for (int m = 0; m < 2; m++) begin
         tk[m] = 0;
         for (int c = 0; c < NC; c++) hi[m][c] = 0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; en = 1'b0; load = 1'b0; period = '0; duty = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         vec++;
         if (dout[m] !== '0 || dtick[m] !== 1'b0 || dpend[m] !== 1'b0) begin
            errs++;
            $display("FAIL reset_state mode%0d: out=%b tick=%b pend=%b, want 0 0 0", m, dout[m], dtick[m], dpend[m]);
         end
      end
      reset = 1'b1;
   endtask

   task automatic test_defaults();
      en = 1'b1;
      clr();
      repeat (40) begin
         cyc();
         for (int m = 0; m < 2; m++) begin
            vec++;
            if (dout[m] !== m_out[m] || dtick[m] !== m_tick[m] || dpend[m] !== m_pend[m]) begin
               errs++;
               $display("FAIL defaults_cyc mode%0d t=%0t: out=%b tick=%b pend=%b want %b %b %b",
                        m, $time, dout[m], dtick[m], dpend[m], m_out[m], m_tick[m], m_pend[m]);
            end
         end
      end
      for (int m = 0; m < 2; m++) begin
         vec++;
         if (hi[m][0] !== 10 || hi[m][3] !== 10 || tk[m] !== (m == 0 ? 2 : 1)) begin
            errs++;
            $display("FAIL defaults_shape mode%0d: high=%0d ticks=%0d want 10 %0d", m, hi[m][0], tk[m], m == 0 ? 2 : 1);
         end
      end
   endtask

   task automatic test_load_mid();
      int exp_hi [NC];
      exp_hi = '{0, 6, 20, 20};
      repeat (7) cyc();
      period = CW'(10);
      duty   = {8'd15, 8'd10, 8'd3, 8'd0};
      load   = 1'b1;
      cyc();
      load = 1'b0;
      repeat (45) begin
         cyc();
         for (int m = 0; m < 2; m++) begin
            vec++;
            if (dout[m] !== m_out[m] || dtick[m] !== m_tick[m] || dpend[m] !== m_pend[m]) begin
               errs++;
               $display("FAIL load_mid_cyc mode%0d t=%0t: out=%b tick=%b pend=%b want %b %b %b",
                        m, $time, dout[m], dtick[m], dpend[m], m_out[m], m_tick[m], m_pend[m]);
            end
         end
      end
      clr();
      repeat (20) cyc();
      for (int m = 0; m < 2; m++) begin
         vec++;
         if (dpend[m] !== 1'b0) begin
            errs++;
            $display("FAIL load_mid_pend mode%0d: pend=%b want 0", m, dpend[m]);
         end
         for (int c = 0; c < NC; c++) begin
            vec++;
            if (hi[m][c] !== exp_hi[c]) begin
               errs++;
               $display("FAIL load_mid_high mode%0d ch%0d: got %0d want %0d", m, c, hi[m][c], exp_hi[c]);
            end
         end
      end
   endtask

   task automatic test_center();
      int run = 0, maxrun = 0;
      period = CW'(8);
      duty   = {8'd3, 8'd0, 8'd1, 8'd3};
      load   = 1'b1;
      cyc();
      load = 1'b0;
      repeat (50) begin
         cyc();
         run = dout[1][0] ? run + 1 : 0;
         for (int m = 0; m < 2; m++) begin
            vec++;
            if (dout[m] !== m_out[m] || dtick[m] !== m_tick[m] || dpend[m] !== m_pend[m]) begin
               errs++;
               $display("FAIL center_cyc mode%0d t=%0t: out=%b tick=%b pend=%b want %b %b %b",
                        m, $time, dout[m], dtick[m], dpend[m], m_out[m], m_tick[m], m_pend[m]);
            end
         end
      end
      clr();
      repeat (32) begin
         cyc();
         run = dout[1][0] ? run + 1 : 0;
         if (run > maxrun) maxrun = run;
         if (dtick[1]) begin
            vec++;
            // The turnaround at cnt=0 is the 4th cycle of the 6-cycle high pulse.
            if (run !== 4) begin
               errs++;
               $display("FAIL center_tick_pos: run at tick=%0d want 4", run);
            end
         end
      end
      vec++;
      if (hi[1][0] !== 12 || maxrun !== 6 || tk[1] !== 2) begin
         errs++;
         $display("FAIL center_shape: high=%0d maxrun=%0d ticks=%0d want 12 6 2", hi[1][0], maxrun, tk[1]);
      end
      vec++;
      if (hi[0][0] !== 12 || tk[0] !== 4) begin
         errs++;
         $display("FAIL center_edge_shape: high=%0d ticks=%0d want 12 4", hi[0][0], tk[0]);
      end
   endtask

   task automatic test_load_boundary();
      int guard = 0;
      int exp_hi [NC];
      exp_hi = '{8, 0, 20, 16};
      while (m_ph[0] != 0 && guard < 64) begin
         cyc();
         guard++;
      end
      vec++;
      if (guard >= 64) begin
         errs++;
         $display("FAIL load_bnd_wait: no boundary within %0d cycles", guard);
      end
      period = CW'(6); duty = {8'd1, 8'd1, 8'd1, 8'd1}; load = 1'b1;
      cyc();
      load = 1'b0;
      cyc();
      period = CW'(5); duty = {8'd4, 8'd5, 8'd0, 8'd2}; load = 1'b1;
      cyc();
      load = 1'b0;
      repeat (40) begin
         cyc();
         for (int m = 0; m < 2; m++) begin
            vec++;
            if (dout[m] !== m_out[m] || dtick[m] !== m_tick[m] || dpend[m] !== m_pend[m]) begin
               errs++;
               $display("FAIL load_bnd_cyc mode%0d t=%0t: out=%b tick=%b pend=%b want %b %b %b",
                        m, $time, dout[m], dtick[m], dpend[m], m_out[m], m_tick[m], m_pend[m]);
            end
         end
      end
      clr();
      repeat (20) cyc();
      for (int m = 0; m < 2; m++)
         for (int c = 0; c < NC; c++) begin
            vec++;
            if (hi[m][c] !== exp_hi[c]) begin
               errs++;
               $display("FAIL load_bnd_high mode%0d ch%0d: got %0d want %0d", m, c, hi[m][c], exp_hi[c]);
            end
         end
   endtask

   task automatic test_en_drop();
      int exp_hi [NC];
      exp_hi = '{14, 4, 0, 6};
      repeat (3) cyc();
      en = 1'b0; period = CW'(7); duty = {8'd3, 8'd0, 8'd2, 8'd7}; load = 1'b1;
      cyc();
      load = 1'b0;
      for (int m = 0; m < 2; m++) begin
         vec++;
         if (dout[m] !== '0 || dtick[m] !== 1'b0 || dpend[m] !== 1'b1) begin
            errs++;
            $display("FAIL en_drop_first mode%0d: out=%b tick=%b pend=%b want 0 0 1", m, dout[m], dtick[m], dpend[m]);
         end
      end
      cyc();
      for (int m = 0; m < 2; m++) begin
         vec++;
         if (dout[m] !== '0 || dpend[m] !== 1'b0) begin
            errs++;
            $display("FAIL en_drop_apply mode%0d: out=%b pend=%b want 0 0", m, dout[m], dpend[m]);
         end
      end
      repeat (3) cyc();
      en = 1'b1;
      clr();
      repeat (14) begin
         cyc();
         for (int m = 0; m < 2; m++) begin
            vec++;
            if (dout[m] !== m_out[m] || dtick[m] !== m_tick[m] || dpend[m] !== m_pend[m]) begin
               errs++;
               $display("FAIL en_rise_cyc mode%0d t=%0t: out=%b tick=%b pend=%b want %b %b %b",
                        m, $time, dout[m], dtick[m], dpend[m], m_out[m], m_tick[m], m_pend[m]);
            end
         end
      end
      for (int m = 0; m < 2; m++) begin
         vec++;
         if (tk[m] !== (m == 0 ? 2 : 1)) begin
            errs++;
            $display("FAIL en_rise_ticks mode%0d: got %0d want %0d", m, tk[m], m == 0 ? 2 : 1);
         end
         for (int c = 0; c < NC; c++) begin
            vec++;
            if (hi[m][c] !== exp_hi[c]) begin
               errs++;
               $display("FAIL en_rise_high mode%0d ch%0d: got %0d want %0d", m, c, hi[m][c], exp_hi[c]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      period = CW'(3); duty = {8'd9, 8'd9, 8'd9, 8'd9}; load = 1'b1;
      cyc();
      load = 1'b0;
      repeat (10) cyc();
      period = CW'(4); load = 1'b1;
      cyc();
      load = 1'b0;
      reset = 1'b0;
      #2;
      for (int m = 0; m < 2; m++) begin
         vec++;
         if (dout[m] !== '0 || dtick[m] !== 1'b0 || dpend[m] !== 1'b0) begin
            errs++;
            $display("FAIL reset_mid mode%0d: out=%b tick=%b pend=%b want 0 0 0", m, dout[m], dtick[m], dpend[m]);
         end
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      clr();
      repeat (40) begin
         cyc();
         for (int m = 0; m < 2; m++) begin
            vec++;
            if (dout[m] !== m_out[m] || dtick[m] !== m_tick[m] || dpend[m] !== m_pend[m]) begin
               errs++;
               $display("FAIL reset_resume_cyc mode%0d t=%0t: out=%b tick=%b pend=%b want %b %b %b",
                        m, $time, dout[m], dtick[m], dpend[m], m_out[m], m_tick[m], m_pend[m]);
            end
         end
      end
      for (int m = 0; m < 2; m++) begin
         vec++;
         if (hi[m][1] !== 10 || tk[m] !== (m == 0 ? 2 : 1)) begin
            errs++;
            $display("FAIL reset_resume_shape mode%0d: high=%0d ticks=%0d want 10 %0d", m, hi[m][1], tk[m], m == 0 ? 2 : 1);
         end
      end
   endtask

   task automatic test_random();
      repeat (600) begin
         load = ($urandom_range(0, 7) == 0);
         if (load) begin
            period = CW'($urandom_range(0, 12));
            for (int c = 0; c < NC; c++) duty[c*CW +: CW] = CW'($urandom_range(0, 14));
         end
         if ($urandom_range(0, 31) == 0) en = !en;
         cyc();
         for (int m = 0; m < 2; m++) begin
            vec++;
            if (dout[m] !== m_out[m] || dtick[m] !== m_tick[m] || dpend[m] !== m_pend[m]) begin
               errs++;
               $display("FAIL random_cyc mode%0d t=%0t: out=%b tick=%b pend=%b want %b %b %b",
                        m, $time, dout[m], dtick[m], dpend[m], m_out[m], m_tick[m], m_pend[m]);
            end
         end
      end
      load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_load_mid();
      test_center();
      test_load_boundary();
      test_en_drop();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Parametrised multi-channel PWM generator and successor to the single-output fixed-period PWM block. A shared period counter drives N_CH independent duty comparators. Period and duty values are runtime-programmable through double-buffered shadow registers, and the counter supports edge-aligned or center-aligned counting. It sits between the control/register logic and the actuator pins (servos, LED dimming, motor bridges).

## Interface
- CNT_W, default 18: counter, period and duty width.
- N_CH, default 4: number of PWM outputs.
- ALIGN, default 0: 0 = edge-aligned (up-count), 1 = center-aligned (up/down).
- PERIOD_RST, default 200000: active period after reset.
- DUTY_RST, default 20000: active duty of every channel after reset.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- en  in  1  run enable; low holds counter and forces outputs low.
- period  in  CNT_W  requested period P, in counts.
- duty  in  N_CH*CNT_W  requested duty D_i; channel i occupies bits [i*CNT_W +: CNT_W].
- load  in  1  one-cycle strobe; captures period/duty into shadow regs.
- out  out  N_CH  PWM outputs, registered; reset 0.
- period_tick  out  1  one-cycle pulse at each period boundary; reset 0.
- load_pending  out  1  shadow holds values not yet active; reset 0.

## Operation
- Registers: cnt (CNT_W), dir (UP/DOWN, center mode only), shadow P/D, active P/D, pending flag.
- P=0 is treated as P=1 everywhere.
- Edge mode: cnt runs 0,1,…,P-1, then 0. Period = P cycles.
- Center mode FSM:
  - UP: increment; when cnt==P-1, go to DOWN and hold cnt for one cycle.
  - DOWN: decrement; when cnt==0, go to UP and hold 0 for one cycle.
  - Sequence per period: 0…P-1, P-1…0. Period = 2P cycles.
- Boundary: the cycle in which cnt is 0 and a new period begins.
  - Edge mode: after cnt==P-1.
  - Center mode: entry to UP.
- Channel i: out_i <= en & (cnt < D_i_active).
  - High time per period, edge mode: min(D_i, P) cycles.
  - High time per period, center mode: 2·min(D_i, P) cycles.
  - D_i=0 gives constant low; D_i≥P gives constant high.
- load: shadow <= period/duty and pending <= 1. A second load before the boundary overwrites the shadow.
- At a boundary with pending=1: active <= shadow, pending <= 0.
- load in the same cycle as a boundary: captured into the shadow and applied at the following boundary. The current boundary uses the old shadow state.
- en low:
  - cnt <= 0, dir <= UP, out <= 0, no period_tick.
  - Pending shadow is applied the next cycle (every cycle counts as a boundary).
- en rising: counting starts from cnt=0; the first period is full length.
- reset asserted mid-operation:
  - cnt=0, dir=UP, out=0, period_tick=0, pending=0.
  - Active P=PERIOD_RST, every active D=DUTY_RST, shadow = same.

## Timing
- out lags cnt by one cycle, a fixed one-cycle latency from the comparison.
- period_tick is registered. It is high in the cycle out reflects cnt=0 of the new period, aligned with the first output cycle that uses the new active values.
- New values take effect ≤ one full period after load; they are never applied mid-period.
- Arithmetic: cnt is unsigned CNT_W and never exceeds P-1, so no overflow. Comparisons are unsigned and full width.

## Structure
- Package pwm_pkg holds:
  - align_e (ALIGN_EDGE, ALIGN_CENTER).
  - dir_e (UP, DOWN).
  - Reset-default constants.
- Sub-module pwm_channel, instantiated N_CH times. It holds one channel's shadow/active duty and output flop, and takes cnt, boundary, load and en as inputs.
- Top level owns the counter, dir FSM, period shadow/active registers, pending flag and period_tick.

## Test plan
- Reset defaults, edge mode, en=1: all outs high for 20000 cycles, then low for 180000; period_tick every 200000 cycles.
- load P=10, D={0,3,10,15} mid-period: old waveform completes; then high counts are 0, 3, 10, 10 per 10-cycle period; load_pending clears at the boundary.
- Center mode, P=8, D_0=3: out_0 high 6 consecutive cycles centered on the cnt=0 turnaround, with a 16-cycle period; dir toggles at cnt 7 and 0.
- load asserted in the boundary cycle, then a second load with different values 2 cycles later: only the second set appears, one period later.
- en dropped mid-period: out=0 the next cycle and cnt=0; pending load applied while low; en re-raised gives a full first period with new values.
- reset pulsed mid-period after reprogramming: outputs 0 immediately; after release, PERIOD_RST/DUTY_RST behaviour resumes from cnt=0.
